// File: rtl/mem_burst_master.sv
// Burst initiator for a single-port memory with 1-cycle registered read; streams beats over valid/ready.
// Define MEM_MASTER_ERR_EN to reject bursts that would run past the top address (err pulse, no execution).
module mem_burst_master #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rdata_valid,
  input  logic                  rdata_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] count;
  logic                  done_q;

  logic                  vld_p1;
  logic                  out_vld_p2;
  logic [DATA_WIDTH-1:0] out_data_p2;
  logic                  skid_vld_p2;
  logic [DATA_WIDTH-1:0] skid_data_p2;

  logic                  cmd_fire;
  logic                  wr_fire;
  logic                  rd_pop;
  logic                  rd_issue;
  logic                  out_hold;
  logic                  last_beat;
  logic                  reject;
  logic [1:0]            occupancy;

  assign cmd_ready   = (state == S_IDLE) && !rst;
  assign cmd_fire    = cmd_valid && cmd_ready;
  assign wdata_ready = (state == S_WRITE) && !rst;
  assign wr_fire     = wdata_valid && wdata_ready;

  assign mem_we   = wr_fire;
  assign mem_addr = addr;
  assign mem_data = (state == S_WRITE) ? wdata : '0;

  assign busy      = (state != S_IDLE);
  assign done      = done_q;
  assign last_beat = (count == '0);

  // Reads in flight plus words held; a word popped this cycle frees its slot immediately.
  assign occupancy = {1'b0, vld_p1} + {1'b0, out_vld_p2} + {1'b0, skid_vld_p2};
  assign rd_pop    = out_vld_p2 && rdata_ready;
  assign out_hold  = out_vld_p2 && !rd_pop;
  assign rd_issue  = (state == S_READ) &&
                     ((occupancy < 2'd2) || ((occupancy == 2'd2) && rd_pop));

`ifdef MEM_MASTER_ERR_EN
  function automatic logic crosses_top(input logic [ADDR_WIDTH-1:0] a,
                                       input logic [ADDR_WIDTH-1:0] l);
    logic [ADDR_WIDTH:0] last_addr;
    last_addr = {1'b0, a} + {1'b0, l};
    return last_addr[ADDR_WIDTH];
  endfunction

  logic err_q;

  assign reject = crosses_top(cmd_addr, cmd_len);
  assign err    = err_q;

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= cmd_fire && reject;
  end
`else
  assign reject = 1'b0;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      addr   <= '0;
      count  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_fire && !reject) begin
            addr  <= cmd_addr;
            count <= cmd_len;
            state <= cmd_we ? S_WRITE : S_READ;
          end
        end
        S_WRITE: begin
          if (wr_fire) begin
            addr <= addr + ADDR_ONE;
            if (last_beat) begin
              state  <= S_IDLE;
              done_q <= 1'b1;
            end else begin
              count <= count - ADDR_ONE;
            end
          end
        end
        S_READ: begin
          if (rd_issue) begin
            addr <= addr + ADDR_ONE;
            if (last_beat) state <= S_DRAIN;
            else           count <= count - ADDR_ONE;
          end
        end
        S_DRAIN: begin
          if (!vld_p1 && !out_vld_p2 && !skid_vld_p2) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage p1: address issued last cycle, its word is on mem_out now
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= rd_issue;
  end

  // Stage p2: presented word plus one skid entry absorbing backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_p2  <= 1'b0;
      skid_vld_p2 <= 1'b0;
    end else if (out_hold) begin
      if (vld_p1) skid_vld_p2 <= 1'b1;
    end else if (skid_vld_p2) begin
      out_vld_p2  <= 1'b1;
      skid_vld_p2 <= vld_p1;
    end else begin
      out_vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_p2 <= '0;
    end else if (!out_hold) begin
      if (skid_vld_p2)  out_data_p2 <= skid_data_p2;
      else if (vld_p1)  out_data_p2 <= mem_out;
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p1 && (out_hold || skid_vld_p2)) skid_data_p2 <= mem_out;
  end

  assign rdata_valid = out_vld_p2;
  assign rdata       = out_data_p2;

endmodule
